hv_mem_responder: RTL and testbench
===================================

# hv_mem_responder

Memory-side responder for the spatial encoder's hypervector fetch interface. Stores one modality's item-memory (IM) rows and negative/positive projection rows. Accepts a row address over a valid/ready request channel and returns the three `HV_WIDTH`-bit rows for that address over a valid/ready response channel after a fixed read latency. One instance serves each modality bank trio; it is the responder on the interface the encoder initiates.

## Interface
- `HV_WIDTH`, 2000: hypervector width in bits (`HV_DIMENSION`).
- `DEPTH`, 214: rows per array; legal addresses are 0..`DEPTH`-1.
- `ADDR_WIDTH`, 8: address width; must satisfy 2^`ADDR_WIDTH` >= `DEPTH`.
- `READ_LATENCY`, 2: cycles from request acceptance to response valid; legal range 1..4.

Ports:
- `Clk_CI` in 1: the single clock. All logic is clocked on the rising edge.
- `Reset_RI` in 1: reset, synchronous and active-high.
- `WrEn_SI` in 1: load strobe.
- `WrSel_DI` in 2: load target. 0 = IM, 1 = projection-negative, 2 = projection-positive, 3 = ignored.
- `WrAddr_DI` in `ADDR_WIDTH`: load row.
- `WrData_DI` in `HV_WIDTH`: load data.
- `ReqValid_SI` in 1: request valid.
- `ReqReady_SO` out 1: request ready.
- `ReqAddr_DI` in `ADDR_WIDTH`: requested row.
- `RespValid_SO` out 1: response valid.
- `RespReady_SI` in 1: consumer ready.
- `IMOut_DO` out `HV_WIDTH`: IM row.
- `ProjNeg_DO` out `HV_WIDTH`: projection-negative row.
- `ProjPos_DO` out `HV_WIDTH`: projection-positive row.
- `AddrErr_SO` out 1: sticky out-of-range flag.

## Operation
- FSM states:
  - IDLE: `ReqReady_SO`=1. A request is accepted when `ReqValid_SI`=1 and `ReqReady_SO`=1. On acceptance the address is latched and the three arrays are read. The next state is HOLD if `READ_LATENCY`=1, otherwise READ.
  - READ: `ReqReady_SO`=0. A latency counter runs; the FSM moves to HOLD when the counter reaches `READ_LATENCY`-1.
  - HOLD: `RespValid_SO`=1. The three data outputs are stable until `RespReady_SI`=1. On the handshake the FSM goes to IDLE (base build).
- Read data reflects array contents at the acceptance cycle:
  - A same-cycle write to the requested row returns old data.
  - Writes during READ or HOLD do not change the pending response.
- Out-of-range requests (address >= `DEPTH`):
  - The request is accepted normally.
  - All three outputs are all-zero.
  - `AddrErr_SO` sets and stays set until reset.
- Loads:
  - Loads are accepted in any state and complete in one cycle.
  - Loads to an out-of-range row or with `WrSel_DI`=3 are dropped silently.
  - Loads do not set `AddrErr_SO`.
- Data outputs are all-zero whenever `RespValid_SO`=0.

## Timing
- Reset values:
  - State = IDLE.
  - `ReqReady_SO`=1. This is combinational from the state, so it is 1 in the cycle after reset.
  - `RespValid_SO`=0, `AddrErr_SO`=0, all data outputs zero.
  - Array contents are not cleared.
- Latency: a request accepted at edge t gives `RespValid_SO`=1 from cycle t+`READ_LATENCY`.
- Reset asserted mid-READ or mid-HOLD:
  - The pending response is discarded.
  - The state returns to IDLE on the next edge.
- Base throughput: one response per `READ_LATENCY`+1 cycles under continuous valid/ready.
- A request in READ or HOLD is not accepted: `ReqReady_SO`=0. The consumer must hold `ReqValid_SI` and `ReqAddr_DI` stable until accepted.

## Configuration
- `HV_MEM_PIPELINE_EN` defined: in HOLD, `ReqReady_SO`=`RespReady_SI`. A request accepted in the same cycle as the response handshake latches its address, and the FSM goes straight to READ, or stays in HOLD with new data when `READ_LATENCY`=1. Back-to-back throughput becomes one response per `READ_LATENCY` cycles, i.e. one per cycle for latency 1.
- Undefined: the base behaviour above. `ReqReady_SO` is 0 outside IDLE.

## Test plan
- Load IM/neg/pos row 5 with all-ones, all-zeros and alternating 1010…; reset; request row 5 with `READ_LATENCY`=2 -> `RespValid_SO` rises exactly 2 cycles after acceptance with the three patterns.
- Hold `RespReady_SI`=0 for 10 cycles in HOLD -> outputs and valid stay stable; raise ready -> next cycle `RespValid_SO`=0 and `ReqReady_SO`=1.
- Request row 213, then row 214 -> row 213 data returned; row 214 returns zeros and `AddrErr_SO`=1 until reset.
- Write row 7 with new data in the acceptance cycle of a row-7 request -> old data returned; a following request for row 7 returns the new data.
- Stream rows 0..31 with ready tied high -> base build gives 32 responses in 96 cycles (latency 2); with `HV_MEM_PIPELINE_EN` it takes 64 cycles, in order, with no drops.
- Assert `Reset_RI` one cycle into READ -> no response emitted, `ReqReady_SO`=1 after reset, and the next request completes normally.

Source files
------------

// File: rtl/hv_mem_responder_if.sv
// Request/response channel between the spatial encoder (master) and the
// hypervector memory responder (slave). Clock and reset stay outside.
interface hv_mem_responder_if #(
    parameter int HV_WIDTH   = 2000,
    parameter int ADDR_WIDTH = 8
) ();
    logic                  ReqValid_SI;
    logic                  ReqReady_SO;
    logic [ADDR_WIDTH-1:0] ReqAddr_DI;
    logic                  RespValid_SO;
    logic                  RespReady_SI;
    logic [HV_WIDTH-1:0]   IMOut_DO;
    logic [HV_WIDTH-1:0]   ProjNeg_DO;
    logic [HV_WIDTH-1:0]   ProjPos_DO;

    modport master (
        output ReqValid_SI, ReqAddr_DI, RespReady_SI,
        input  ReqReady_SO, RespValid_SO, IMOut_DO, ProjNeg_DO, ProjPos_DO
    );

    modport slave (
        input  ReqValid_SI, ReqAddr_DI, RespReady_SI,
        output ReqReady_SO, RespValid_SO, IMOut_DO, ProjNeg_DO, ProjPos_DO
    );
endinterface

// File: rtl/hv_mem_responder.sv
// hv_mem_responder: holds the item-memory and the negative/positive projection
// rows of one modality and returns all three rows of a requested address after
// a fixed read latency.
// Optional feature: define HV_MEM_PIPELINE_EN to accept the next request in
// the same cycle as the response handshake (back-to-back responses).
module hv_mem_responder #(
    parameter int HV_WIDTH     = 2000,
    parameter int DEPTH        = 214,
    parameter int ADDR_WIDTH   = 8,
    parameter int READ_LATENCY = 2
) (
    input  logic                  Clk_CI,
    input  logic                  Reset_RI,
    input  logic                  WrEn_SI,
    input  logic [1:0]            WrSel_DI,
    input  logic [ADDR_WIDTH-1:0] WrAddr_DI,
    input  logic [HV_WIDTH-1:0]   WrData_DI,
    hv_mem_responder_if.slave     bus,
    output logic                  AddrErr_SO
);

    localparam int                    CNT_WIDTH = 3;
    localparam logic [CNT_WIDTH-1:0]  CNT_LAST  = CNT_WIDTH'(READ_LATENCY - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // True when the row exists in the arrays.
    function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] addr);
        return ({1'b0, addr} < DEPTH_EXT);
    endfunction

    logic [HV_WIDTH-1:0] im_mem  [DEPTH];
    logic [HV_WIDTH-1:0] neg_mem [DEPTH];
    logic [HV_WIDTH-1:0] pos_mem [DEPTH];

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 addr_err_q, addr_err_d;
    logic [HV_WIDTH-1:0]  im_q, im_d;
    logic [HV_WIDTH-1:0]  neg_q, neg_d;
    logic [HV_WIDTH-1:0]  pos_q, pos_d;

    logic                 wr_ok_s;
    logic                 req_ready_s;
    logic                 accept_s;
    logic                 resp_hs_s;
    logic                 resp_valid_s;
    logic [HV_WIDTH-1:0]  rd_im_s, rd_neg_s, rd_pos_s;
    logic [HV_WIDTH-1:0]  im_out_s, neg_out_s, pos_out_s;

    assign wr_ok_s = WrEn_SI && addr_in_range(WrAddr_DI) && (WrSel_DI != 2'd3);

    // Load port: one row of one array per cycle, illegal targets are dropped.
    always_ff @(posedge Clk_CI) begin
        if (wr_ok_s) begin
            case (WrSel_DI)
                2'd0:    im_mem[WrAddr_DI]  <= WrData_DI;
                2'd1:    neg_mem[WrAddr_DI] <= WrData_DI;
                2'd2:    pos_mem[WrAddr_DI] <= WrData_DI;
                default: ;
            endcase
        end
    end

    // Array read of the requested row; out-of-range rows read as zero.
    always_comb begin
        rd_im_s  = '0;
        rd_neg_s = '0;
        rd_pos_s = '0;
        if (addr_in_range(bus.ReqAddr_DI)) begin
            rd_im_s  = im_mem[bus.ReqAddr_DI];
            rd_neg_s = neg_mem[bus.ReqAddr_DI];
            rd_pos_s = pos_mem[bus.ReqAddr_DI];
        end else begin
            rd_im_s  = '0;
            rd_neg_s = '0;
            rd_pos_s = '0;
        end
    end

    // Request ready: always in IDLE, and in HOLD only when pipelining overlaps
    // the next acceptance with the response handshake.
    always_comb begin
        req_ready_s = 1'b0;
        case (state_q)
            ST_IDLE: req_ready_s = 1'b1;
`ifdef HV_MEM_PIPELINE_EN
            ST_HOLD: req_ready_s = bus.RespReady_SI;
`endif
            default: req_ready_s = 1'b0;
        endcase
    end

    assign accept_s  = bus.ReqValid_SI && req_ready_s;
    assign resp_hs_s = (state_q == ST_HOLD) && bus.RespReady_SI;

    // Next state, latency counter, captured row data and sticky error flag.
    // Data is captured at acceptance so later loads cannot alter a pending
    // response, and a same-cycle load to the row still returns the old data.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_err_d = addr_err_q;
        im_d       = im_q;
        neg_d      = neg_q;
        pos_d      = pos_q;
        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if (accept_s) begin
                    state_d = (READ_LATENCY == 1) ? ST_HOLD : ST_READ;
                    cnt_d   = 3'd1;
                end else if (resp_hs_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            ST_READ: begin
                if (cnt_q >= CNT_LAST) begin
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (accept_s) begin
            im_d       = rd_im_s;
            neg_d      = rd_neg_s;
            pos_d      = rd_pos_s;
            addr_err_d = addr_err_q | ~addr_in_range(bus.ReqAddr_DI);
        end else begin
            im_d       = im_q;
            neg_d      = neg_q;
            pos_d      = pos_q;
            addr_err_d = addr_err_q;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge Clk_CI) begin
        if (Reset_RI) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 3'd0;
            addr_err_q <= 1'b0;
            im_q       <= '0;
            neg_q      <= '0;
            pos_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_err_q <= addr_err_d;
            im_q       <= im_d;
            neg_q      <= neg_d;
            pos_q      <= pos_d;
        end
    end

    // Response outputs: data is forced to zero whenever no response is valid.
    always_comb begin
        resp_valid_s = (state_q == ST_HOLD);
        im_out_s     = '0;
        neg_out_s    = '0;
        pos_out_s    = '0;
        if (resp_valid_s) begin
            im_out_s  = im_q;
            neg_out_s = neg_q;
            pos_out_s = pos_q;
        end else begin
            im_out_s  = '0;
            neg_out_s = '0;
            pos_out_s = '0;
        end
    end

    assign bus.ReqReady_SO  = req_ready_s;
    assign bus.RespValid_SO = resp_valid_s;
    assign bus.IMOut_DO     = im_out_s;
    assign bus.ProjNeg_DO   = neg_out_s;
    assign bus.ProjPos_DO   = pos_out_s;
    assign AddrErr_SO       = addr_err_q;

endmodule

// File: tb/tb_hv_mem_responder.sv
// Scoreboard bench for hv_mem_responder: a plain-array memory model produces
// the expected rows at request acceptance; a monitor checks every response.
module tb_hv_mem_responder;
    localparam int HV    = 2000;
    localparam int DEPTH = 214;
    localparam int AW    = 8;
    localparam int LAT   = 2;
`ifdef HV_MEM_PIPELINE_EN
    localparam int PERIOD = LAT;
`else
    localparam int PERIOD = LAT + 1;
`endif

    typedef struct {
        logic [HV-1:0] im;
        logic [HV-1:0] neg;
        logic [HV-1:0] pos;
        int            cyc;
    } exp_t;

    typedef struct {
        logic [1:0]    sel;
        int            addr;
        logic [HV-1:0] data;
    } wr_t;

    logic          clk     = 1'b0;
    logic          rst     = 1'b1;
    logic          wr_en   = 1'b0;
    logic [1:0]    wr_sel  = 2'd0;
    logic [AW-1:0] wr_addr = '0;
    logic [HV-1:0] wr_data = '0;
    logic          addr_err;

    hv_mem_responder_if #(.HV_WIDTH(HV), .ADDR_WIDTH(AW)) bus ();

    hv_mem_responder #(
        .HV_WIDTH(HV), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .READ_LATENCY(LAT)
    ) dut (
        .Clk_CI(clk), .Reset_RI(rst), .WrEn_SI(wr_en), .WrSel_DI(wr_sel),
        .WrAddr_DI(wr_addr), .WrData_DI(wr_data), .bus(bus), .AddrErr_SO(addr_err)
    );

    always #5 clk = ~clk;

    // Reference memory and scoreboard state.
    logic [HV-1:0] m_im [DEPTH];
    logic [HV-1:0] m_neg[DEPTH];
    logic [HV-1:0] m_pos[DEPTH];
    bit            m_err = 1'b0;
    exp_t          exp_q[$];
    int            pop_cycs[$];
    wr_t           wq[$];
    int            checks = 0;
    int            passes = 0;
    int            cyc = 0;
    bit            mon_on = 1'b0;
    bit            seen = 1'b0;
    bit            rand_wr = 1'b0;
    bit            rdy_rand = 1'b0;
    bit            rdy_val = 1'b1;

    function automatic logic [HV-1:0] rand_hv();
        logic [HV-1:0] v = '0;
        for (int i = 0; i < (HV + 31) / 32; i++) v = {v[HV-33:0], $urandom()};
        return v;
    endfunction

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic chk_hv(input string name, input logic [HV-1:0] act, input logic [HV-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got low64=%h expected low64=%h", name, act[63:0], exp[63:0]);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Model of the arrays: a load lands when it is legal.
    always @(posedge clk) begin
        if (wr_en && wr_sel != 2'd3 && int'(wr_addr) < DEPTH) begin
            case (wr_sel)
                2'd0:    m_im[wr_addr]  <= wr_data;
                2'd1:    m_neg[wr_addr] <= wr_data;
                2'd2:    m_pos[wr_addr] <= wr_data;
                default: ;
            endcase
        end
    end

    // Load driver: directed loads from wq first, else optional random loads.
    always begin
        @(posedge clk);
        #2;
        if (wq.size() > 0) begin
            wr_t w;
            w = wq.pop_front();
            wr_en = 1'b1; wr_sel = w.sel; wr_addr = AW'(w.addr); wr_data = w.data;
        end else if (rand_wr && $urandom_range(0, 2) == 0) begin
            wr_en   = 1'b1;
            wr_sel  = 2'($urandom_range(0, 3));
            wr_addr = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(0, 255))
                                                  : AW'($urandom_range(0, DEPTH - 1));
            wr_data = rand_hv();
        end else begin
            wr_en = 1'b0;
        end
    end

    // Consumer ready driver.
    always begin
        @(posedge clk);
        #3;
        bus.RespReady_SI = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_val;
    end

    // Monitor: compares every presented response against the scoreboard head.
    always @(negedge clk) begin
        if (mon_on) begin
            if (bus.RespValid_SO) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_resp: got valid=1 expected no pending response");
                end else begin
                    if (!seen) chk_int("resp_latency", cyc, exp_q[0].cyc);
                    chk_hv("im_data", bus.IMOut_DO, exp_q[0].im);
                    chk_hv("neg_data", bus.ProjNeg_DO, exp_q[0].neg);
                    chk_hv("pos_data", bus.ProjPos_DO, exp_q[0].pos);
                    if (bus.RespReady_SI) begin
                        void'(exp_q.pop_front());
                        pop_cycs.push_back(cyc);
                        seen = 1'b0;
                    end else begin
                        seen = 1'b1;
                    end
                end
            end else begin
                seen = 1'b0;
                chk_hv("idle_zero", bus.IMOut_DO | bus.ProjNeg_DO | bus.ProjPos_DO, '0);
            end
        end
    end

    // Expected response of a request accepted at the coming edge.
    task automatic push_req(input int addr);
        exp_t e;
        if (addr < DEPTH) begin
            e.im = m_im[addr]; e.neg = m_neg[addr]; e.pos = m_pos[addr];
        end else begin
            e.im = '0; e.neg = '0; e.pos = '0;
            m_err = 1'b1;
        end
        e.cyc = cyc + LAT;
        exp_q.push_back(e);
    endtask

    // Issue n requests for rows base.. with valid held high until all accepted.
    task automatic stream(input int base, input int n);
        int i = 0;
        int idle = 0;
        bus.ReqValid_SI = 1'b1;
        bus.ReqAddr_DI  = AW'(base);
        while (i < n && idle < 200) begin
            @(negedge clk);
            if (bus.ReqReady_SO) begin
                push_req(base + i);
                i++;
                idle = 0;
            end else begin
                idle++;
            end
            @(posedge clk);
            #1;
            if (i < n) bus.ReqAddr_DI = AW'(base + i);
        end
        bus.ReqValid_SI = 1'b0;
        if (i < n) chk_int("req_accept_timeout", i, n);
    endtask

    task automatic wait_drain();
        int b = 0;
        while (exp_q.size() > 0 && b < 500) begin
            @(posedge clk);
            b++;
        end
        chk_int("drain", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic flush_writes();
        int b = 0;
        while (wq.size() > 0 && b < 2000) begin
            @(posedge clk);
            b++;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Reset starting now (called at posedge+1); discards pending expectations.
    task automatic do_reset();
        mon_on = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        m_err = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_on = 1'b1;
    endtask

    initial begin
        logic [HV-1:0] ones;
        logic [HV-1:0] alt;
        int span;
        ones = '1;
        alt  = {(HV / 2){2'b10}};
        bus.ReqValid_SI = 1'b0;
        bus.ReqAddr_DI  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_on = 1'b1;
        @(negedge clk);
        chk_int("reset_req_ready", int'(bus.ReqReady_SO), 1);
        chk_int("reset_resp_valid", int'(bus.RespValid_SO), 0);
        chk_int("reset_addr_err", int'(addr_err), 0);
        @(posedge clk);
        #1;

        // Fill every row of all three arrays with random data.
        for (int r = 0; r < DEPTH; r++)
            for (int s = 0; s < 3; s++) wq.push_back('{sel: 2'(s), addr: r, data: rand_hv()});
        flush_writes();

        // Row 5 patterns survive a reset and come back after LAT cycles.
        wq.push_back('{sel: 2'd0, addr: 5, data: ones});
        wq.push_back('{sel: 2'd1, addr: 5, data: '0});
        wq.push_back('{sel: 2'd2, addr: 5, data: alt});
        flush_writes();
        do_reset();
        stream(5, 1);
        wait_drain();

        // Stall in HOLD for 10 cycles, then release.
        rdy_val = 1'b0;
        stream(17, 1);
        begin
            int b = 0;
            do begin
                @(negedge clk);
                b++;
            end while (!bus.RespValid_SO && b < 20);
        end
        for (int k = 0; k < 10; k++) begin
            chk_int("hold_valid", int'(bus.RespValid_SO), 1);
            @(negedge clk);
        end
        rdy_val = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        chk_int("release_valid", int'(bus.RespValid_SO), 0);
        chk_int("release_req_ready", int'(bus.ReqReady_SO), 1);
        @(posedge clk);
        #1;

        // Last legal row, first illegal row, sticky error until reset.
        stream(213, 1);
        wait_drain();
        chk_int("err_after_213", int'(addr_err), 0);
        stream(214, 1);
        wait_drain();
        chk_int("err_after_214", int'(addr_err), 1);
        stream(3, 1);
        wait_drain();
        chk_int("err_sticky", int'(addr_err), int'(m_err));
        do_reset();
        @(negedge clk);
        chk_int("err_cleared", int'(addr_err), 0);
        @(posedge clk);
        #1;

        // Load row 7 in the acceptance cycle of a row-7 request: old data, then new.
        wq.push_back('{sel: 2'd0, addr: 7, data: rand_hv()});
        wq.push_back('{sel: 2'd1, addr: 7, data: rand_hv()});
        stream(7, 1);
        wait_drain();
        stream(7, 1);
        wait_drain();

        // Reset one cycle into READ: response discarded, next request works.
        stream(9, 1);
        do_reset();
        @(negedge clk);
        chk_int("rst_read_req_ready", int'(bus.ReqReady_SO), 1);
        for (int k = 0; k < 5; k++) begin
            chk_int("rst_read_no_resp", int'(bus.RespValid_SO), 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        stream(9, 1);
        wait_drain();

        // Stream rows 0..31 with ready high: count and steady-state spacing.
        pop_cycs.delete();
        stream(0, 32);
        wait_drain();
        chk_int("stream_count", pop_cycs.size(), 32);
        span = (pop_cycs.size() == 32) ? pop_cycs[31] - pop_cycs[0] : -1;
        chk_int("stream_span", span, 31 * PERIOD);

        // Random requests with random loads and random consumer stalls.
        rand_wr  = 1'b1;
        rdy_rand = 1'b1;
        for (int k = 0; k < 40; k++) begin
            int a;
            a = ($urandom_range(0, 9) == 0) ? $urandom_range(DEPTH, 255)
                                            : $urandom_range(0, DEPTH - 1);
            stream(a, 1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        rand_wr  = 1'b0;
        rdy_rand = 1'b0;
        wait_drain();
        chk_int("rand_addr_err", int'(addr_err), int'(m_err));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1);
    end
endmodule
